// File: rtl/tf_coeff_sram_ctrl.sv
// Coefficient SRAM sequencer: streamed load, paced debug readout and two-requester read arbitration.
// Define TF_COEFF_CTRL_CHECKSUM_EN to add a running modulo-2^DATA_WIDTH checksum of loaded words.
//
// state    | meaning
// IDLE     | waiting for a command; read requesters are arbitrated onto the R/RW ports
// LOAD     | accepting coefficient words from the stream into the SRAM
// DBG_WAIT | two-cycle gap while the SRAM presents the next debug word
// DBG_OUT  | debug word offered on the readout stream
module tf_coeff_sram_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 2048
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_load,
  input  logic                  cmd_debug,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic                  busy,
  output logic                  done,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  dbg_valid,
  output logic [DATA_WIDTH-1:0] dbg_data,
  input  logic                  dbg_ready,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  sram_load,
  output logic                  sram_wdata_valid,
  output logic                  sram_debug,
  output logic                  sram_debug_read_trig,
  output logic                  sram_ren,
  output logic                  sram_rwen,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic [ADDR_WIDTH-1:0] sram_radr,
  output logic [ADDR_WIDTH-1:0] sram_rwadr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic [DATA_WIDTH-1:0] sram_rwdata
`ifdef TF_COEFF_CTRL_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  // one extra bit so a count equal to DEPTH is representable
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DBG_WAIT, DBG_OUT} state_t;

  state_t          state;
  logic [CW-1:0]   len_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   len_ext;
  logic [CW-1:0]   len_clamp;
  logic            wait_cnt;
  logic            rv1_rw;
  logic            arb_en;

  assign len_ext   = {1'b0, len};
  assign len_clamp = (len_ext > DEPTH_C) ? DEPTH_C : len_ext;
  assign cnt_inc   = cnt + CW'(1);

  assign busy = (state != IDLE);

  // requesters see the SRAM only while idle and out of reset
  assign arb_en     = rst_n && (state == IDLE);
  assign gnt0       = arb_en && req0;
  assign gnt1       = arb_en && req1;
  assign sram_ren   = gnt0 || gnt1;
  assign sram_radr  = gnt0 ? addr0 : (gnt1 ? addr1 : '0);
  assign sram_rwen  = gnt0 && gnt1;
  assign sram_rwadr = sram_rwen ? addr1 : '0;

  assign rdata0 = rvalid0 ? sram_rdata : '0;
  assign rdata1 = rvalid1 ? (rv1_rw ? sram_rwdata : sram_rdata) : '0;

  assign sram_load        = (state == LOAD);
  assign s_ready          = sram_load && (cnt < len_q);
  assign sram_wdata_valid = s_valid && s_ready;
  assign sram_wdata       = sram_load ? s_data : '0;

  assign sram_debug           = (state == DBG_WAIT) || (state == DBG_OUT);
  assign dbg_valid            = (state == DBG_OUT);
  assign dbg_data             = dbg_valid ? sram_rdata : '0;
  assign sram_debug_read_trig = dbg_valid && dbg_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      len_q    <= '0;
      cnt      <= '0;
      wait_cnt <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rv1_rw   <= 1'b0;
    end else begin
      done    <= 1'b0;
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      rv1_rw  <= gnt0 && gnt1;
      case (state)
        IDLE: begin
          if (cmd_load || cmd_debug) begin
            len_q    <= len_clamp;
            cnt      <= '0;
            wait_cnt <= 1'b1;
            if (len_clamp == '0) begin
              done <= 1'b1;
            end else if (cmd_load) begin
              state <= LOAD;
            end else begin
              state <= DBG_WAIT;
            end
          end
        end
        LOAD: begin
          if (sram_wdata_valid) begin
            cnt <= cnt_inc;
            if (cnt_inc == len_q) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        DBG_WAIT: begin
          if (wait_cnt == 1'b0) begin
            state <= DBG_OUT;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DBG_OUT: begin
          if (dbg_ready) begin
            cnt      <= cnt_inc;
            wait_cnt <= 1'b1;
            if (cnt_inc == len_q) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= DBG_WAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TF_COEFF_CTRL_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if ((state == IDLE) && cmd_load) begin
      checksum <= '0;
    end else if (sram_wdata_valid) begin
      checksum <= checksum + s_data;
    end
  end
`endif

endmodule

// File: tb/tb_tf_coeff_sram_ctrl.sv
// Randomized bench for tf_coeff_sram_ctrl with an auto-incrementing SRAM macro model and a reference memory image.
module tb_tf_coeff_sram_ctrl;
  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int DEPTH = 2048;
  localparam int LIMIT = 6000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_load, cmd_debug;
  logic [AW-1:0] len;
  logic          busy, done;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          dbg_valid, dbg_ready;
  logic [DW-1:0] dbg_data;
  logic          req0, req1, gnt0, gnt1, rvalid0, rvalid1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] rdata0, rdata1;
  logic          sram_load, sram_wdata_valid, sram_debug, sram_debug_read_trig, sram_ren, sram_rwen;
  logic [DW-1:0] sram_wdata, sram_rdata, sram_rwdata;
  logic [AW-1:0] sram_radr, sram_rwadr;
  logic [DW-1:0] cks_view;
`ifdef TF_COEFF_CTRL_CHECKSUM_EN
  logic [DW-1:0] checksum;
  assign cks_view = checksum;
`else
  assign cks_view = '0;
`endif

  int n_checks;
  int n_fail;

  tf_coeff_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_load(cmd_load), .cmd_debug(cmd_debug), .len(len),
    .busy(busy), .done(done), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .sram_load(sram_load), .sram_wdata_valid(sram_wdata_valid), .sram_debug(sram_debug),
    .sram_debug_read_trig(sram_debug_read_trig), .sram_ren(sram_ren), .sram_rwen(sram_rwen),
    .sram_wdata(sram_wdata), .sram_radr(sram_radr), .sram_rwadr(sram_rwadr),
    .sram_rdata(sram_rdata), .sram_rwdata(sram_rwdata)
`ifdef TF_COEFF_CTRL_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [14+5*DW+2*AW-1:0] all_out;
  assign all_out = {busy, done, s_ready, dbg_valid, gnt0, gnt1, rvalid0, rvalid1,
                    sram_load, sram_wdata_valid, sram_debug, sram_debug_read_trig, sram_ren, sram_rwen,
                    dbg_data, rdata0, rdata1, sram_wdata, sram_radr, sram_rwadr, cks_view};

  // SRAM macro model: load and debug modes walk an internal pointer from word 0
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int wptr, dptr;
  always @(posedge clk) begin
    if (!sram_load) wptr <= 0;
    else if (sram_wdata_valid) begin
      if (wptr < DEPTH) mem[wptr[10:0]] <= sram_wdata;
      wptr <= wptr + 1;
    end
    if (!sram_debug) dptr <= 0;
    else if (sram_debug_read_trig) dptr <= dptr + 1;
    if (sram_ren) sram_rdata <= mem[sram_radr[10:0]];
    else if (sram_debug) sram_rdata <= mem[dptr[10:0]];
    if (sram_rwen) sram_rwdata <= mem[sram_rwadr[10:0]];
  end

  logic [DW-1:0] load_q[$];
  logic [DW-1:0] wr_seen[$];
  logic [DW-1:0] dbg_seen[$];
  int            hs_cyc[$];

  task automatic run_load(input int len_v, input int gap_pct, input bit both,
                          output int n_wr, output int last_wr, output int done_at, output int n_done);
    int idx;
    idx = 0; n_wr = 0; last_wr = -1; done_at = -1; n_done = 0;
    wr_seen.delete();
    cmd_load = 1'b1; cmd_debug = both; len = AW'(len_v);
    @(posedge clk); #1;
    cmd_load = 1'b0; cmd_debug = 1'b0;
    for (int cyc = 0; cyc < LIMIT; cyc++) begin
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0) s_valid = 1'b1;
      else s_valid = (idx < load_q.size()) && ($urandom_range(99) >= gap_pct);
      s_data = (idx < load_q.size()) ? load_q[idx] : DW'($urandom);
      #1;
      if (sram_wdata_valid) begin
        n_wr++; last_wr = cyc; wr_seen.push_back(sram_wdata); idx++;
      end
      if (done_at >= 0 && cyc >= done_at + 3) break;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic run_debug(input int len_v, input int rdy_pct, output int done_at, output int n_done);
    done_at = -1; n_done = 0;
    dbg_seen.delete(); hs_cyc.delete();
    cmd_debug = 1'b1; len = AW'(len_v);
    @(posedge clk); #1;
    cmd_debug = 1'b0;
    for (int cyc = 0; cyc < LIMIT; cyc++) begin
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = cyc;
      end
      dbg_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (dbg_valid && dbg_ready) begin
        dbg_seen.push_back(dbg_data); hs_cyc.push_back(cyc);
      end
      if (done_at >= 0 && cyc >= done_at + 2) break;
      @(posedge clk); #1;
    end
    dbg_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_load = 1'($urandom); req0 = 1'($urandom); req1 = 1'($urandom);
      addr0 = AW'($urandom); addr1 = AW'($urandom); s_valid = 1'($urandom);
      s_data = DW'($urandom); dbg_ready = 1'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (all_out !== '0) begin
        n_fail++; $display("FAIL reset_outputs[%0d]: got %h want 0", i, all_out);
      end
    end
    cmd_load = 0; req0 = 0; req1 = 0; s_valid = 0; dbg_ready = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_release_idle: got %b want 00", {busy, done});
    end
  endtask

  task automatic test_load();
    int n_wr, last_wr, done_at, n_done, bad;
    load_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    run_load(4, 50, 1'b0, n_wr, last_wr, done_at, n_done);
    n_checks++;
    if (n_wr !== 4) begin n_fail++; $display("FAIL load_writes: got %0d want 4", n_wr); end
    n_checks++;
    if (done_at !== last_wr + 1) begin
      n_fail++; $display("FAIL load_done_lag: done at %0d want %0d", done_at, last_wr + 1);
    end
    n_checks++;
    if (n_done !== 1) begin n_fail++; $display("FAIL load_done_count: got %0d want 1", n_done); end
    bad = (wr_seen.size() != 4) ? 1 : 0;
    for (int i = 0; i < 4 && i < wr_seen.size(); i++) if (wr_seen[i] !== load_q[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL load_wdata: %0d bad words, want 0", bad); end
`ifdef TF_COEFF_CTRL_CHECKSUM_EN
    n_checks++;
    if (checksum !== 16'h00AA) begin n_fail++; $display("FAIL load_checksum: got %h want 00aa", checksum); end
`endif
    for (int i = 0; i < 4; i++) ref_mem[i] = load_q[i];
  endtask

  task automatic test_debug();
    int done_at, n_done, bad;
    run_debug(4, 100, done_at, n_done);
    bad = (dbg_seen.size() != 4) ? 1 : 0;
    for (int i = 0; i < 4 && i < dbg_seen.size(); i++) begin
      if (dbg_seen[i] !== DW'((i + 1) * 'h11)) bad++;
      if (hs_cyc[i] != 3 * i + 2) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL debug_sequence: %0d bad words/timings, want 0", bad); end
    n_checks++;
    if (done_at !== 12 || n_done !== 1) begin
      n_fail++; $display("FAIL debug_done: at %0d count %0d want at 12 count 1", done_at, n_done);
    end
  endtask

  task automatic test_boundary();
    int n_wr, last_wr, done_at, n_done, bad;
    logic [DW-1:0] sum;
    load_q = '{16'h1234, 16'h5678, 16'h9abc};
    run_load(0, 0, 1'b0, n_wr, last_wr, done_at, n_done);
    n_checks++;
    if (n_wr !== 0 || done_at !== 0 || n_done !== 1) begin
      n_fail++; $display("FAIL len0: writes %0d done_at %0d count %0d want 0 0 1", n_wr, done_at, n_done);
    end
`ifdef TF_COEFF_CTRL_CHECKSUM_EN
    n_checks++;
    if (checksum !== '0) begin n_fail++; $display("FAIL len0_checksum: got %h want 0", checksum); end
`endif
    load_q.delete();
    for (int i = 0; i < 6; i++) load_q.push_back(DW'($urandom));
    run_load(6, 30, 1'b1, n_wr, last_wr, done_at, n_done);
    n_checks++;
    if (n_wr !== 6 || done_at !== last_wr + 1) begin
      n_fail++; $display("FAIL both_cmds_load: writes %0d done_at %0d want 6 at %0d", n_wr, done_at, last_wr + 1);
    end
    load_q.delete();
    for (int i = 0; i < 2100; i++) load_q.push_back(DW'($urandom));
    run_load(4095, 10, 1'b0, n_wr, last_wr, done_at, n_done);
    n_checks++;
    if (n_wr !== DEPTH) begin n_fail++; $display("FAIL clamp_writes: got %0d want %0d", n_wr, DEPTH); end
    n_checks++;
    if (done_at !== last_wr + 1 || n_done !== 1) begin
      n_fail++; $display("FAIL clamp_done: at %0d count %0d want at %0d count 1", done_at, n_done, last_wr + 1);
    end
    bad = 0; sum = '0;
    for (int i = 0; i < DEPTH && i < wr_seen.size(); i++) if (wr_seen[i] !== load_q[i]) bad++;
    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = load_q[i]; sum += load_q[i]; end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL clamp_wdata: %0d bad words, want 0", bad); end
`ifdef TF_COEFF_CTRL_CHECKSUM_EN
    n_checks++;
    if (checksum !== sum) begin n_fail++; $display("FAIL clamp_checksum: got %h want %h", checksum, sum); end
`endif
  endtask

  task automatic test_random();
    int n_wr, last_wr, done_at, n_done, bad, lv, dl;
    logic [DW-1:0] sum;
    for (int it = 0; it < 6; it++) begin
      lv = $urandom_range(40, 1);
      load_q.delete(); sum = '0;
      for (int i = 0; i < lv; i++) begin load_q.push_back(DW'($urandom)); sum += load_q[i]; end
      run_load(lv, $urandom_range(70), 1'b0, n_wr, last_wr, done_at, n_done);
      bad = (wr_seen.size() != lv) ? 1 : 0;
      for (int i = 0; i < lv && i < wr_seen.size(); i++) if (wr_seen[i] !== load_q[i]) bad++;
      n_checks++;
      if (n_wr !== lv || bad != 0 || done_at !== last_wr + 1 || n_done !== 1) begin
        n_fail++;
        $display("FAIL rand_load[%0d]: writes %0d bad %0d done_at %0d count %0d want %0d 0 %0d 1",
                 it, n_wr, bad, done_at, n_done, lv, last_wr + 1);
      end
`ifdef TF_COEFF_CTRL_CHECKSUM_EN
      n_checks++;
      if (checksum !== sum) begin n_fail++; $display("FAIL rand_checksum[%0d]: got %h want %h", it, checksum, sum); end
`endif
      for (int i = 0; i < lv; i++) ref_mem[i] = load_q[i];
      dl = $urandom_range(lv + 5, 1);
      run_debug(dl, $urandom_range(100, 30), done_at, n_done);
      bad = (dbg_seen.size() != dl) ? 1 : 0;
      for (int i = 0; i < dl && i < dbg_seen.size(); i++) if (dbg_seen[i] !== ref_mem[i]) bad++;
      n_checks++;
      if (bad != 0 || n_done !== 1 || hs_cyc.size() == 0 || done_at !== hs_cyc[hs_cyc.size() - 1] + 1) begin
        n_fail++; $display("FAIL rand_debug[%0d]: bad %0d done_at %0d count %0d want 0 after last word, 1", it, bad, done_at, n_done);
      end
    end
  endtask

  task automatic test_arb();
    logic p0, p1, have_prev;
    logic [AW-1:0] pa0, pa1;
    logic [3+2*AW:0] exp_g, obs_g;
    req0 = 1; addr0 = 5; req1 = 1; addr1 = 9;
    #1;
    n_checks++;
    if ({gnt0, gnt1, sram_ren, sram_rwen, sram_radr, sram_rwadr} !== {4'b1111, AW'(5), AW'(9)}) begin
      n_fail++; $display("FAIL arb_both_grant: got %b %0d %0d want 1111 5 9",
                         {gnt0, gnt1, sram_ren, sram_rwen}, sram_radr, sram_rwadr);
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 1; addr1 = 9;
    #1;
    n_checks++;
    if ({rvalid0, rvalid1, rdata0, rdata1} !== {2'b11, ref_mem[5], ref_mem[9]}) begin
      n_fail++; $display("FAIL arb_both_rdata: got %b %h %h want 11 %h %h",
                         {rvalid0, rvalid1}, rdata0, rdata1, ref_mem[5], ref_mem[9]);
    end
    n_checks++;
    if ({gnt0, gnt1, sram_ren, sram_rwen, sram_radr} !== {4'b0110, AW'(9)}) begin
      n_fail++; $display("FAIL arb_req1_alone: got %b radr %0d want 0110 radr 9", {gnt0, gnt1, sram_ren, sram_rwen}, sram_radr);
    end
    @(posedge clk); #1;
    req1 = 0;
    #1;
    n_checks++;
    if ({rvalid0, rvalid1, rdata1} !== {2'b01, ref_mem[9]}) begin
      n_fail++; $display("FAIL arb_req1_rdata: got %b %h want 01 %h", {rvalid0, rvalid1}, rdata1, ref_mem[9]);
    end
    have_prev = 0; p0 = 0; p1 = 0; pa0 = '0; pa1 = '0;
    for (int it = 0; it < 40; it++) begin
      @(posedge clk); #1;
      req0 = 1'($urandom); req1 = 1'($urandom);
      addr0 = AW'($urandom_range(DEPTH - 1)); addr1 = AW'($urandom_range(DEPTH - 1));
      #1;
      exp_g = {req0, req1, req0 | req1, req0 & req1,
               req0 ? addr0 : (req1 ? addr1 : AW'(0)), (req0 & req1) ? addr1 : AW'(0)};
      obs_g = {gnt0, gnt1, sram_ren, sram_rwen,
               (req0 | req1) ? sram_radr : AW'(0), (req0 & req1) ? sram_rwadr : AW'(0)};
      n_checks++;
      if (obs_g !== exp_g) begin n_fail++; $display("FAIL arb_rand_grant[%0d]: got %h want %h", it, obs_g, exp_g); end
      if (have_prev) begin
        n_checks++;
        if ({rvalid0, rvalid1, p0 ? rdata0 : DW'(0), p1 ? rdata1 : DW'(0)} !==
            {p0, p1, p0 ? ref_mem[pa0] : DW'(0), p1 ? ref_mem[pa1] : DW'(0)}) begin
          n_fail++; $display("FAIL arb_rand_rdata[%0d]: got %b %h %h want %b %h %h", it, {rvalid0, rvalid1},
                             rdata0, rdata1, {p0, p1}, ref_mem[pa0], ref_mem[pa1]);
        end
      end
      p0 = req0; p1 = req1; pa0 = addr0; pa1 = addr1; have_prev = 1;
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
  endtask

  task automatic test_stall();
    int n_wr, bad, got_gnt, fin;
    logic [DW-1:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = DW'($urandom);
    n_wr = 0; bad = 0; got_gnt = -1; fin = 0;
    cmd_load = 1; len = 3;
    @(posedge clk); #1;
    cmd_load = 0; req0 = 1; addr0 = 100;
    for (int cyc = 0; cyc < 200 && fin == 0; cyc++) begin
      cmd_debug = busy;
      s_valid = (n_wr < 3) ? 1'($urandom) : 1'b0;
      s_data = (n_wr < 3) ? w[n_wr] : '0;
      #1;
      if (done) begin
        got_gnt = int'(gnt0); fin = 1;
      end else begin
        if (gnt0 !== 1'b0) bad++;
        if (sram_wdata_valid) n_wr++;
        @(posedge clk); #1;
      end
    end
    cmd_debug = 0; s_valid = 0;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL stall_gnt_busy: %0d grants while busy, want 0", bad); end
    n_checks++;
    if (got_gnt != 1 || n_wr != 3) begin
      n_fail++; $display("FAIL stall_first_idle: gnt0 %0d writes %0d want 1 3", got_gnt, n_wr);
    end
    @(posedge clk); #1;
    req0 = 0;
    #1;
    n_checks++;
    if ({rvalid0, rdata0, sram_debug, busy} !== {1'b1, ref_mem[100], 2'b00}) begin
      n_fail++; $display("FAIL stall_rvalid: got %b %h dbg %b busy %b want 1 %h 0 0",
                         rvalid0, rdata0, sram_debug, busy, ref_mem[100]);
    end
    for (int i = 0; i < 3; i++) ref_mem[i] = w[i];
  endtask

  task automatic test_reset_midload();
    int n, saw_done, done_at, n_done, bad;
    load_q.delete();
    for (int i = 0; i < 4; i++) load_q.push_back(DW'($urandom));
    cmd_load = 1; len = 4;
    @(posedge clk); #1;
    cmd_load = 0; n = 0; saw_done = 0;
    for (int cyc = 0; cyc < 100 && n < 2; cyc++) begin
      s_valid = 1; s_data = load_q[n];
      #1;
      if (sram_wdata_valid) n++;
      if (done) saw_done = 1;
      @(posedge clk); #1;
    end
    s_valid = 0; rst_n = 0;
    if (done) saw_done = 1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
      n_checks++;
      if (all_out !== '0) begin n_fail++; $display("FAIL midload_reset_outputs[%0d]: got %h want 0", i, all_out); end
    end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    n_checks++;
    if (saw_done != 0 || n != 2) begin
      n_fail++; $display("FAIL midload_no_done: done seen %0d writes %0d want 0 2", saw_done, n);
    end
    run_debug(2, 100, done_at, n_done);
    bad = (dbg_seen.size() != 2) ? 1 : 0;
    for (int i = 0; i < 2 && i < dbg_seen.size(); i++) if (dbg_seen[i] !== load_q[i]) bad++;
    n_checks++;
    if (bad != 0 || n_done !== 1) begin
      n_fail++; $display("FAIL midload_readback: bad %0d done count %0d want 0 1", bad, n_done);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 0; cmd_load = 0; cmd_debug = 0; len = '0; s_valid = 0; s_data = '0;
    dbg_ready = 0; req0 = 0; req1 = 0; addr0 = '0; addr1 = '0;
    #1;
    test_reset();
    test_load();
    test_debug();
    test_boundary();
    test_random();
    test_arb();
    test_stall();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tf_coeff_sram_ctrl.md
TF_COEFF_SRAM_CTRL -- requirements
Module: tf_coeff_sram_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, coefficient word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, SRAM address width.
REQ-003 The block SHALL have parameter DEPTH, default 2048, SRAM words.
REQ-004 The block SHALL have ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_load, cmd_debug  in  1 each  start load or debug readout (sampled in IDLE only).
- len  in  ADDR_WIDTH  word count for the started command.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.
- s_valid  in  1; s_data  in  DATA_WIDTH; s_ready  out  1  coefficient load stream.
- dbg_valid  out  1; dbg_data  out  DATA_WIDTH; dbg_ready  in  1  debug readout stream.
- reqN  in  1; addrN  in  ADDR_WIDTH; gntN  out  1; rvalidN  out  1; rdataN  out  DATA_WIDTH  read requester N, N = 0, 1.
- sram_load, sram_wdata_valid, sram_debug, sram_debug_read_trig, sram_ren, sram_rwen  out  1  SRAM interface controls.
- sram_wdata  out  DATA_WIDTH; sram_radr, sram_rwadr  out  ADDR_WIDTH  SRAM interface data and addresses.
- sram_rdata, sram_rwdata  in  DATA_WIDTH  SRAM read-only and read/write port data.

Function
REQ-005 FSM states SHALL be IDLE, LOAD, DBG_WAIT, DBG_OUT; encoding is free.
REQ-006 In IDLE, cmd_load SHALL win over cmd_debug when both are high. len is captured. len = 0 SHALL pulse done next cycle and stay in IDLE. len > DEPTH SHALL clamp to DEPTH.
REQ-007 LOAD behaviour:
- sram_load = 1.
- s_ready = 1 while the transfer count is below the captured len.
- sram_wdata_valid = s_valid & s_ready, combinationally.
- sram_wdata = s_data, combinationally.
REQ-008 The transfer count SHALL increment on each s_valid & s_ready. The cycle after the last transfer, the block SHALL pulse done and return to IDLE, with sram_load = 0.
REQ-009 While in DBG_WAIT or DBG_OUT, sram_debug SHALL be 1.
REQ-010 DBG_WAIT SHALL last exactly 2 cycles, then go to DBG_OUT.
REQ-011 DBG_OUT behaviour:
- dbg_valid = 1 and dbg_data = sram_rdata.
- On dbg_ready, sram_debug_read_trig SHALL pulse for 1 cycle and the word count SHALL increment.
- After len words, pulse done and go to IDLE; otherwise return to DBG_WAIT.
REQ-012 Arbitration SHALL apply in IDLE only:
- If only one requester is active, it gets the R port (sram_ren = 1, sram_radr = addr).
- If both are active, req0 gets the R port and req1 gets the RW port (sram_rwen = 1, sram_rwadr = addr1).
- gntN SHALL be combinational in the same cycle.
REQ-013 rvalidN SHALL assert exactly 1 cycle after gntN. rdataN SHALL be taken from the port granted in the previous cycle.
REQ-014 In any non-IDLE state, gnt0, gnt1, sram_ren (controller-driven) and sram_rwen SHALL be 0; requesters stall.
REQ-015 A command arriving while busy SHALL be ignored, with no queuing.

Reset
REQ-016 While rst_n = 0 at a clock edge, the block SHALL:
- go to IDLE and clear all counters;
- drive busy, done, s_ready, dbg_valid, gnt*, rvalid*, and all sram_* controls to 0;
- drive all address and data outputs to 0.
REQ-017 Reset mid-LOAD or mid-debug SHALL abort without a done pulse. Words already written SHALL remain in the SRAM.

Configuration
REQ-018 With TF_COEFF_CTRL_CHECKSUM_EN defined:
- output checksum [DATA_WIDTH-1:0] SHALL hold the modulo-2^DATA_WIDTH sum of the words accepted in the current load;
- it SHALL clear when a load starts and on reset;
- it SHALL be stable from the done pulse onward.
REQ-019 Without TF_COEFF_CTRL_CHECKSUM_EN, the checksum port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-020 Load: cmd_load with len=4, words 0x0011, 0x0022, 0x0033, 0x0044 with s_valid gapped -> exactly 4 sram_wdata_valid pulses, done 1 cycle after the 4th, checksum=0x00AA when enabled.
REQ-021 Debug: after REQ-020, cmd_debug with len=4, dbg_ready held high -> dbg_data sequence 0x0011, 0x0022, 0x0033, 0x0044, 3 cycles per word, then done.
REQ-022 Arbitration: req0 (addr 5) and req1 (addr 9) in the same cycle -> sram_radr=5, sram_rwadr=9, both rvalid 1 cycle later with the correct data; req1 alone -> served on the R port.
REQ-023 Stall: req0 held high during a len=3 load -> gnt0 stays 0 until IDLE, then grants on the first IDLE cycle.
REQ-024 Boundary cases: len=0 load -> done the next cycle with no writes; len=4095 -> exactly 2048 writes; cmd_load and cmd_debug together -> load runs.
REQ-025 Reset: rst_n low after the 2nd word of a len=4 load -> no done pulse, all outputs 0, and a following cmd_debug len=2 reads the two written words.
